// File: rtl/aes_state_reg_if.sv
// Bus bundle for aes_state_reg: load/round-update inputs and registered state outputs.
// master = block driving loads and round results, slave = the state register.
interface aes_state_reg_if #(
  parameter int W = 128
);
  logic           load;
  logic [W-1:0]   din;
  logic [W-1:0]   rin;
  logic           rvalid;
  logic [W-1:0]   state;
  logic [3:0]     round;
  logic           busy;
  logic           done;
  logic           sel_ld;
  logic           sel_rf;
  logic [W/8-1:0] par;

  modport master (
    output load, din, rin, rvalid,
    input  state, round, busy, done, sel_ld, sel_rf, par
  );

  modport slave (
    input  load, din, rin, rvalid,
    output state, round, busy, done, sel_ld, sel_rf, par
  );
endinterface

// File: rtl/aes_state_reg.sv
// AES round state register: loads the initial state, then takes NR round results.
// Optional macro AES_STATE_PARITY_EN adds registered per-byte even parity on par.
module aes_state_reg #(
  parameter int NR = 10,
  parameter int W  = 128
) (
  input  logic           clk,
  input  logic           rstb,
  aes_state_reg_if.slave bus
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } fsm_t;

  localparam logic [3:0] LAST_ROUND = 4'(NR);

  fsm_t       fsm;
  logic [3:0] round_nxt;

  assign round_nxt = bus.round + 4'd1;

  // Selects are registered so the downstream AO22 mux sees glitch-free, one-hot
  // controls: sel_ld while idle (next load), sel_rf while a block runs.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      fsm       <= IDLE;
      bus.state <= '0;
      bus.round <= '0;
      bus.busy  <= 1'b0;
      bus.done  <= 1'b0;
      bus.sel_ld <= 1'b1;
      bus.sel_rf <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every flop samples pre-edge values.
      bus.done <= 1'b0;
      case (fsm)
        IDLE: begin
          if (bus.load) begin
            fsm        <= RUN;
            bus.state  <= bus.din;
            bus.round  <= '0;
            bus.busy   <= 1'b1;
            bus.sel_ld <= 1'b0;
            bus.sel_rf <= 1'b1;
          end
        end
        RUN: begin
          if (bus.rvalid) begin
            bus.state <= bus.rin;
            bus.round <= round_nxt;
            if (round_nxt == LAST_ROUND) begin
              fsm        <= IDLE;
              bus.busy   <= 1'b0;
              bus.done   <= 1'b1;
              bus.sel_ld <= 1'b1;
              bus.sel_rf <= 1'b0;
            end
          end
        end
        default: fsm <= IDLE;
      endcase
    end
  end

`ifdef AES_STATE_PARITY_EN
  function automatic logic [W/8-1:0] byte_parity(input logic [W-1:0] v);
    logic [W/8-1:0] p;
    p = '0;
    for (int i = 0; i < W/8; i++) p[i] = ^v[8*i +: 8];
    return p;
  endfunction

  logic         par_we;
  logic [W-1:0] par_src;

  // Parity tracks exactly the value written into state on the same edge.
  always_comb begin
    par_we  = 1'b0;
    par_src = bus.din;
    if (fsm == IDLE) begin
      par_we  = bus.load;
      par_src = bus.din;
    end else begin
      par_we  = bus.rvalid;
      par_src = bus.rin;
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      // NOTE: parity is reset along with state so par stays consistent with state=0.
      bus.par <= '0;
    end else if (par_we) begin
      bus.par <= byte_parity(par_src);
    end
  end
`else
  assign bus.par = '0;
`endif

endmodule

// File: tb/tb_aes_state_reg.sv
// Scoreboard bench for aes_state_reg: expected block results are queued at load time
// and popped by a monitor on every done pulse; directed checks cover load, stall and reset.
module tb_aes_state_reg;
  localparam int NR = 10;
  localparam int W  = 128;
  localparam int NB = W/8;

  typedef struct {
    logic [W-1:0]  state;
    logic [3:0]    round;
    logic [NB-1:0] par;
  } exp_t;

  logic clk  = 1'b0;
  logic rstb = 1'b0;
  always #5 clk = ~clk;

  aes_state_reg_if #(.W(W)) bus();

  aes_state_reg #(.NR(NR), .W(W)) dut (
    .clk  (clk),
    .rstb (rstb),
    .bus  (bus)
  );

  int   checks      = 0;
  int   errors      = 0;
  int   done_pulses = 0;
  exp_t sb[$];

  localparam logic [W-1:0] D1   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [W-1:0] D1F  = 128'h00112233445566778899aabbccddef09;
  localparam logic [W-1:0] D3   = 128'h0123456789abcdeffedcba9876543210;
  localparam logic [W-1:0] D3R4 = 128'h0123456789abcdeffedcba9876543214;
  localparam logic [W-1:0] D3F  = 128'h0123456789abcdeffedcba987654321a;
  localparam logic [W-1:0] ONES = {W{1'b1}};

`ifdef AES_STATE_PARITY_EN
  localparam logic [NB-1:0] PAR_ONE_LOAD = 16'h0001;
`else
  localparam logic [NB-1:0] PAR_ONE_LOAD = 16'h0000;
`endif

  function automatic logic [NB-1:0] par_of(input logic [W-1:0] v);
    logic [NB-1:0] p;
    p = '0;
`ifdef AES_STATE_PARITY_EN
    for (int i = 0; i < NB; i++) p[i] = ^v[8*i +: 8];
`endif
    return p;
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [W-1:0] st, input logic [3:0] rd);
    exp_t e;
    e.state = st;
    e.round = rd;
    e.par   = par_of(st);
    sb.push_back(e);
  endtask

  // Feed round results rin = state + 1 for n consecutive edges.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      bus.rin    = bus.state + 1'b1;
      bus.rvalid = 1'b1;
      tick();
    end
    bus.rvalid = 1'b0;
  endtask

  // Monitor: invariants every cycle, scoreboard pop on each done pulse.
  always @(negedge clk) begin
    if (rstb) begin
      check("sel_exclusive", W'(bus.sel_ld & bus.sel_rf), '0);
      check("round_le_nr", W'(bus.round > 4'(NR)), '0);
      if (bus.done) begin
        done_pulses++;
        check("sb_nonempty", W'(sb.size() != 0), W'(1));
        if (sb.size() != 0) begin
          exp_t e;
          e = sb.pop_front();
          check("sb_state", bus.state, e.state);
          check("sb_round", W'(bus.round), W'(e.round));
          check("sb_par", W'(bus.par), W'(e.par));
          check("sb_busy", W'(bus.busy), '0);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.load   = 1'b0;
    bus.din    = '0;
    bus.rin    = '0;
    bus.rvalid = 1'b0;
    repeat (2) @(negedge clk);

    check("rst_state", bus.state, '0);
    check("rst_round", W'(bus.round), '0);
    check("rst_busy", W'(bus.busy), '0);
    check("rst_done", W'(bus.done), '0);
    check("rst_sel_ld", W'(bus.sel_ld), W'(1));
    check("rst_sel_rf", W'(bus.sel_rf), '0);
    check("rst_par", W'(bus.par), '0);

    // Block 1: load accepted on the first edge after reset release, 10 back-to-back rounds.
    bus.din  = D1;
    bus.load = 1'b1;
    push(D1F, 4'd10);
    @(negedge clk);
    rstb = 1'b1;
    tick();
    bus.load = 1'b0;
    check("t1_load_state", bus.state, D1);
    check("t1_load_round", W'(bus.round), '0);
    check("t1_load_busy", W'(bus.busy), W'(1));
    check("t1_load_sel_ld", W'(bus.sel_ld), '0);
    check("t1_load_sel_rf", W'(bus.sel_rf), W'(1));
    step(NR - 1);
    check("t1_r9_done", W'(bus.done), '0);
    check("t1_r9_round", W'(bus.round), W'(9));
    step(1);
    // The done cycle is the (NR+1)th cycle counting the load cycle as the first.
    check("t1_done", W'(bus.done), W'(1));
    check("t1_done_busy", W'(bus.busy), '0);
    check("t1_done_sel_ld", W'(bus.sel_ld), W'(1));
    check("t1_final_state", bus.state, D1F);
    // Idle: rvalid is ignored and the result holds.
    bus.rin    = 128'hdeadbeef;
    bus.rvalid = 1'b1;
    tick();
    bus.rvalid = 1'b0;
    check("t1_hold_done", W'(bus.done), '0);
    check("t1_hold_state", bus.state, D1F);
    check("t1_hold_round", W'(bus.round), W'(10));

    // Block 2: rvalid alternating 1,0 -> 9 stalls before the 10th update.
    bus.din  = '0;
    bus.load = 1'b1;
    push(W'(10), 4'd10);
    tick();
    bus.load = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      bus.rin    = bus.state + 1'b1;
      bus.rvalid = (k % 2) == 1;
      tick();
      if (k == 2)  check("t2_stall_round", W'(bus.round), W'(1));
      if (k == 3)  check("t2_step_round", W'(bus.round), W'(2));
      if (k == 18) check("t2_not_done", W'(bus.done), '0);
      if (k == 19) check("t2_done", W'(bus.done), W'(1));
    end
    bus.rvalid = 1'b0;

    // Block 3: load during run at round 4 is ignored.
    bus.din  = D3;
    bus.load = 1'b1;
    push(D3F, 4'd10);
    tick();
    bus.load = 1'b0;
    step(4);
    check("t3_round4", W'(bus.round), W'(4));
    bus.din  = ONES;
    bus.load = 1'b1;
    tick();
    bus.load = 1'b0;
    check("t3_ign_state", bus.state, D3R4);
    check("t3_ign_round", W'(bus.round), W'(4));
    check("t3_ign_busy", W'(bus.busy), W'(1));
    step(6);
    check("t3_done", W'(bus.done), W'(1));

    // Block 4: load in the done cycle, then reset at round 5 abandons it.
    bus.din  = ONES;
    bus.load = 1'b1;
    tick();
    bus.load = 1'b0;
    check("t4_load_state", bus.state, ONES);
    check("t4_load_round", W'(bus.round), '0);
    check("t4_load_busy", W'(bus.busy), W'(1));
    check("t4_load_done", W'(bus.done), '0);
    step(5);
    check("t4_r5_round", W'(bus.round), W'(5));
    check("t4_r5_state", bus.state, W'(4));
    #1 rstb = 1'b0;
    #1;
    check("t4_rst_state", bus.state, '0);
    check("t4_rst_round", W'(bus.round), '0);
    check("t4_rst_busy", W'(bus.busy), '0);
    check("t4_rst_sel_ld", W'(bus.sel_ld), W'(1));
    check("t4_rst_sel_rf", W'(bus.sel_rf), '0);
    check("t4_rst_done", W'(bus.done), '0);
    check("t4_rst_par", W'(bus.par), '0);

    // Block 5: load and rvalid together in idle -> load wins; parity of 0x01.
    bus.din    = W'(1);
    bus.load   = 1'b1;
    bus.rin    = 128'h5555;
    bus.rvalid = 1'b1;
    push(W'(11), 4'd10);
    repeat (2) @(negedge clk);
    rstb = 1'b1;
    tick();
    bus.load   = 1'b0;
    bus.rvalid = 1'b0;
    check("t5_load_state", bus.state, W'(1));
    check("t5_load_round", W'(bus.round), '0);
    check("t5_load_par", W'(bus.par), W'(PAR_ONE_LOAD));
    step(NR);
    check("t5_done", W'(bus.done), W'(1));
    tick();

    check("sb_drained", W'(sb.size()), '0);
    check("done_pulses", W'(done_pulses), W'(4));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/aes_state_reg.md
AES_STATE_REG -- requirements
Module: aes_state_reg

Interface
REQ-001 SHALL have parameter NR, default 10, meaning the number of round updates per block (range 1..15).
REQ-002 SHALL have parameter W, default 128, meaning the state width in bits (multiple of 8).
REQ-003 SHALL have port CLK, input, 1 bit: the single clock; all state changes occur on the rising edge.
REQ-004 SHALL have port RSTB, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port LOAD, input, 1 bit: start request, which loads DIN when idle.
REQ-006 SHALL have port DIN, input, W bits: initial state (plaintext XOR key0).
REQ-007 SHALL have port RIN, input, W bits: round-function result computed from the STATE output.
REQ-008 SHALL have port RVALID, input, 1 bit: RIN is valid this cycle.
REQ-009 SHALL have port STATE, output, W bits: registered state.
REQ-010 SHALL have port ROUND, output, 4 bits: registered round count.
REQ-011 SHALL have port BUSY, output, 1 bit: a block is in progress.
REQ-012 SHALL have port DONE, output, 1 bit: one-cycle pulse marking a finished block.
REQ-013 SHALL have ports SEL_LD and SEL_RF, outputs, 1 bit each: one-hot, registered selects driving the downstream AND-OR (AO22) state-input mux.
REQ-014 SHALL have port PAR, output, W/8 bits: per-byte even parity of STATE.

Function
REQ-015 SHALL implement two states, IDLE and RUN; BUSY SHALL be 1 exactly in RUN.
REQ-016 IDLE with LOAD=1 SHALL, at the next edge, perform: STATE<=DIN, ROUND<=0, go to RUN; SEL_LD<=0 and SEL_RF<=1.
REQ-017 IDLE with LOAD=0 SHALL hold STATE and ROUND unchanged; SEL_LD=1, SEL_RF=0.
REQ-018 RUN with RVALID=1 SHALL, at the next edge, perform: STATE<=RIN, ROUND<=ROUND+1.
REQ-019 RUN with RVALID=0 SHALL hold STATE and ROUND as a stall, with no timeout.
REQ-020 On the RUN update that makes ROUND equal NR, the FSM SHALL go to IDLE: DONE=1 for exactly that one following cycle, BUSY=0, and SEL_LD=1, SEL_RF=0 from that cycle.
REQ-021 After completion, STATE and ROUND SHALL hold the final result until the next LOAD.
REQ-022 LOAD asserted in RUN SHALL be ignored, with no effect on STATE, ROUND or the FSM.
REQ-023 LOAD and RVALID both high in IDLE SHALL cause a load only; RVALID SHALL be ignored in IDLE.
REQ-024 LOAD in the DONE cycle, which is IDLE, SHALL be accepted; the new block begins at the next edge.
REQ-025 Minimum latency SHALL be NR+1 cycles from the LOAD edge to the DONE cycle.
REQ-026 ROUND SHALL never exceed NR and SHALL never wrap.
REQ-027 SEL_LD and SEL_RF SHALL never both be 1.

Reset
REQ-028 While RSTB=0, SHALL asynchronously force: FSM=IDLE, STATE=0, ROUND=0, BUSY=0, DONE=0, SEL_LD=1, SEL_RF=0, PAR=0.
REQ-029 Reset asserted mid-block SHALL abandon the block with no DONE pulse.
REQ-030 After RSTB deasserts, SHALL accept LOAD from the first rising edge.

Configuration
REQ-031 Macro AES_STATE_PARITY_EN: when defined, PAR SHALL be a registered output updated on the same edge as STATE, equal to the XOR of each byte of the newly written value (PAR[i] covers STATE[8i+7:8i]).
REQ-032 When AES_STATE_PARITY_EN is undefined, PAR SHALL be tied to 0 and no parity flops SHALL exist; all other behaviour SHALL be identical.

Verification
REQ-033 LOAD=1 with DIN=0x00112233445566778899aabbccddeeff, then RVALID=1 for 10 cycles with RIN=STATE+1 -> STATE=DIN+10, ROUND=10, DONE pulses once at cycle 11 after the LOAD edge, BUSY low afterwards.
REQ-034 RVALID toggling 1,0,1,0 during RUN -> ROUND increments only on RVALID=1 cycles; DONE delayed by exactly the number of stall cycles.
REQ-035 LOAD=1 with DIN=X at ROUND=4 in RUN -> STATE and ROUND unaffected; block completes normally.
REQ-036 RSTB pulsed low at ROUND=5 -> immediately STATE=0, ROUND=0, BUSY=0, SEL_LD=1; no DONE pulse.
REQ-037 LOAD in the DONE cycle with DIN=0xFF..FF -> STATE=0xFF..FF at the next edge, ROUND=0, BUSY=1.
REQ-038 With AES_STATE_PARITY_EN defined, loading DIN=0x01 in byte0 and 0 elsewhere -> PAR=0x0001; undefined -> PAR=0.
